// File: rtl/serial_adder_if.sv
// Operand/result bus between the controller and serial_adder: START/BUSY/DONE handshake
// plus operands in and registered result flags out.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic             busy;
    logic             done;

    modport master (output start, a, b, ci, sub, input  y, c, v, busy, done);
    modport slave  (input  start, a, b, ci, sub, output y, c, v, busy, done);
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands folded through a CHUNK-bit ripple slice per clock.
// Optional ADDER_SAT_EN clamps Y to the signed limit on overflow (C/V stay raw).
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] y_q;
    logic             c_q, v_q, busy_q, done_q;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   add;
    logic             cmsb, v_nxt;
    logic [WIDTH-1:0] res, y_nxt;

    always_comb begin
        a_ch  = a_sh[idx*CHUNK +: CHUNK];
        b_ch  = b_sh[idx*CHUNK +: CHUNK];
        add   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        // Carry into the slice MSB recovered from its sum bit; only used on the last chunk.
        cmsb  = add[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
        v_nxt = add[CHUNK] ^ cmsb;
        res   = sum_sh;
        res[idx*CHUNK +: CHUNK] = add[CHUNK-1:0];
        y_nxt = res;
`ifdef ADDER_SAT_EN
        if (v_nxt)
            y_nxt = a_sh[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            y_q    <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.ci;
                        sum_sh <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= res;
                    carry  <= add[CHUNK];
                    idx    <= idx + 1'b1;
                    if (idx == IDXW'(N-1)) begin
                        idx    <= '0;
                        y_q    <= y_nxt;
                        c_q    <= add[CHUNK];
                        v_q    <= v_nxt;
                        done_q <= 1'b1;
                        state  <= DONE_S;
                    end
                end
                DONE_S: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y    = y_q;
    assign bus.c    = c_q;
    assign bus.v    = v_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
